bp_resolve_queue: RTL and testbench
===================================

// Module: bp_resolve_queue
// PURPOSE
//  In-order checkpoint queue between fetch-time prediction and branch resolution for the gshare predictor.
//  Each predicted branch enqueues {pc, ghist snapshot, prediction}; each in-order resolve dequeues the oldest entry.
//  A resolve emits a PHT training update (index, taken) back to the gshare table.
//  On a mispredict it also emits a global-history repair value and squashes all younger wrong-path entries.
// PARAMETERS
//  DEPTH    8   queue entries; power of 2, >=2
//  PC_W     32  program counter width
//  GHIST_W  12  global history width; equals log2(PHT entries)
//  IDX_W    12  PHT index width; must equal GHIST_W
// PORTS
//  clk            in   1               clock, rising edge
//  rst            in   1               asynchronous, active-low reset
//  flush          in   1               squash all entries (exception/redirect from backend)
//  alloc_v        in   1               fetch predicted a conditional branch
//  alloc_rdy      out  1               queue not full; alloc_fire = alloc_v & alloc_rdy
//  alloc_pc       in   PC_W            branch pc
//  alloc_ghist    in   GHIST_W         history used to form the prediction
//  alloc_pred     in   1               predicted direction (1 = taken)
//  resolve_v      in   1               oldest outstanding branch resolved
//  resolve_rdy    out  1               queue not empty; resolve_fire = resolve_v & resolve_rdy
//  resolve_taken  in   1               actual direction
//  upd_v          out  1               PHT training strobe
//  upd_idx        out  IDX_W           pc[IDX_W+1:2] ^ ghist of the resolved entry
//  upd_taken      out  1               counter direction: increment if 1, decrement if 0
//  repair_v       out  1               mispredict; fetch must reload history
//  repair_ghist   out  GHIST_W         {ghist[GHIST_W-2:0], resolve_taken}
//  occupancy      out  $clog2(DEPTH)+1 valid entry count
// BEHAVIOUR
//  - Reset (rst=0, async): head=tail=0, occupancy=0, upd_v=0, repair_v=0, upd_idx=0, upd_taken=0, repair_ghist=0.
//  - alloc_rdy = (occupancy != DEPTH). resolve_rdy = (occupancy != 0). Neither depends on same-cycle inputs.
//  - alloc_fire: entry written at tail; tail+1 mod DEPTH. Pointers carry an extra wrap bit for the full/empty test.
//  - resolve_fire: reads the entry at head; head+1 mod DEPTH.
//  - Next cycle after resolve_fire: upd_v=1, upd_idx, upd_taken=resolve_taken (1-cycle registered latency).
//  - Mispredict: resolve_fire & (resolve_taken != entry.pred).
//    Next cycle: repair_v=1, repair_ghist as defined above.
//    The queue empties in the same edge (head=tail, occupancy=0), and any same-cycle alloc_fire is discarded (wrong path).
//  - Correct prediction: repair_v=0; a same-cycle alloc and resolve are both honoured, so occupancy is unchanged.
//  - flush has top priority: queue empties, and same-cycle alloc/resolve are ignored (no upd_v, no repair_v next cycle).
//  - upd_v and repair_v are single-cycle pulses and deassert the cycle after.
//  - upd_idx/upd_taken/repair_ghist hold their last values when their strobe is low.
//  - Reset asserted mid-operation discards all entries and clears the pending strobes immediately.
// CONFIGURATION
//  BP_RESOLVE_STATS_EN defined:
//    adds outputs stat_resolves[31:0] and stat_mispredicts[31:0].
//    Both increment on resolve_fire (mispredicts only on mispredict) and saturate at 32'hFFFF_FFFF.
//    Both reset to 0 and are unaffected by flush.
//  BP_RESOLVE_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  - Package bp_pkg:
//    typedef bp_ckpt_t {pc, ghist, pred};
//    function bp_pht_idx(pc, ghist), shared with the gshare index logic;
//    localparams for default GHIST_W and IDX_W.
//  - Sub-module bp_sat_ctr: 32-bit saturating counter, instantiated twice under BP_RESOLVE_STATS_EN.
//  - Storage is a flop array of bp_ckpt_t[DEPTH] with no reset on the data fields; only the pointers reset.
// TESTING
//  1. Reset, then alloc pc=0x100, ghist=0x0A5, pred=1; resolve taken=1 -> next cycle upd_v=1, upd_idx=0x040^0x0A5=0x0E5, upd_taken=1, repair_v=0.
//  2. Alloc 8 entries -> alloc_rdy=0, occupancy=8. Then alloc_v with resolve_fire (correct) in the same cycle -> alloc dropped, occupancy=7.
//  3. Alloc pred=0, ghist=0xFFF, then 3 younger entries; resolve taken=1 on the oldest -> repair_v=1, repair_ghist=0xFFF, occupancy=0.
//  4. flush together with alloc_v and resolve_v on a 3-entry queue -> occupancy=0 next cycle, upd_v=0, repair_v=0.
//  5. Run 20 alloc/resolve pairs across pointer wrap -> upd_idx sequence matches a reference FIFO model.
//  6. With BP_RESOLVE_STATS_EN: 5 resolves containing 2 mispredicts -> stat_resolves=5, stat_mispredicts=2; a counter preloaded to 0xFFFFFFFF holds that value.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared branch-predictor types and helpers: the checkpoint record held per
// in-flight branch and the gshare PHT index hash.
package bp_pkg;

  localparam int BP_PC_W    = 32;
  localparam int BP_GHIST_W = 12;
  localparam int BP_IDX_W   = BP_GHIST_W;

  typedef struct packed {
    logic [BP_PC_W-1:0]    pc;
    logic [BP_GHIST_W-1:0] ghist;
    logic                  pred;
  } bp_ckpt_t;

  // Word-aligned pc bits folded with the history that formed the prediction.
  function automatic logic [BP_IDX_W-1:0] bp_pht_idx(input logic [BP_PC_W-1:0]    pc,
                                                     input logic [BP_GHIST_W-1:0] ghist);
    return pc[BP_IDX_W+1:2] ^ ghist;
  endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
// load takes priority over inc.
module bp_sat_ctr (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        inc,
  output logic [31:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc && (count != 32'hFFFF_FFFF)) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/bp_resolve_queue.sv
// In-order checkpoint queue between gshare prediction and branch resolution.
// Define BP_RESOLVE_STATS_EN to add saturating resolve/mispredict counters.
module bp_resolve_queue
  import bp_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int PC_W    = BP_PC_W,
  parameter int GHIST_W = BP_GHIST_W,
  parameter int IDX_W   = BP_IDX_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     alloc_v,
  output logic                     alloc_rdy,
  input  logic [PC_W-1:0]          alloc_pc,
  input  logic [GHIST_W-1:0]       alloc_ghist,
  input  logic                     alloc_pred,
  input  logic                     resolve_v,
  output logic                     resolve_rdy,
  input  logic                     resolve_taken,
  output logic                     upd_v,
  output logic [IDX_W-1:0]         upd_idx,
  output logic                     upd_taken,
  output logic                     repair_v,
  output logic [GHIST_W-1:0]       repair_ghist,
  output logic [$clog2(DEPTH):0]   occupancy
`ifdef BP_RESOLVE_STATS_EN
  ,
  output logic [31:0]              stat_resolves,
  output logic [31:0]              stat_mispredicts
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  bp_ckpt_t           mem [DEPTH];
  bp_ckpt_t           head_entry;
  bp_ckpt_t           alloc_entry;
  logic [PTR_W:0]     head;
  logic [PTR_W:0]     tail;
  logic               alloc_fire;
  logic               resolve_fire;
  logic               mispredict;
  logic               resolve_ok;
  logic               alloc_ok;

  // Wrap bit in the pointers makes full/empty a plain subtraction.
  assign occupancy    = tail - head;
  assign alloc_rdy    = (occupancy != (PTR_W+1)'(DEPTH));
  assign resolve_rdy  = (occupancy != '0);
  assign alloc_fire   = alloc_v & alloc_rdy;
  assign resolve_fire = resolve_v & resolve_rdy;
  assign head_entry   = mem[head[PTR_W-1:0]];
  assign mispredict   = resolve_fire & (resolve_taken != head_entry.pred);
  assign resolve_ok   = resolve_fire & ~flush;
  // Anything fetched alongside a mispredict is on the wrong path.
  assign alloc_ok     = alloc_fire & ~flush & ~mispredict;

  assign alloc_entry.pc    = alloc_pc;
  assign alloc_entry.ghist = alloc_ghist;
  assign alloc_entry.pred  = alloc_pred;

  // Checkpoint storage: data only, never reset.
  always_ff @(posedge clk) begin
    if (alloc_ok) begin
      mem[tail[PTR_W-1:0]] <= alloc_entry;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
    end else if (flush || mispredict) begin
      head <= tail;
    end else begin
      if (alloc_fire)   tail <= tail + 1'b1;
      if (resolve_fire) head <= head + 1'b1;
    end
  end

  // Training and repair outputs: one cycle behind the resolve.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      upd_v        <= 1'b0;
      upd_idx      <= '0;
      upd_taken    <= 1'b0;
      repair_v     <= 1'b0;
      repair_ghist <= '0;
    end else begin
      upd_v    <= resolve_ok;
      repair_v <= mispredict & ~flush;
      if (resolve_ok) begin
        upd_idx   <= bp_pht_idx(head_entry.pc, head_entry.ghist);
        upd_taken <= resolve_taken;
      end
      if (mispredict && !flush) begin
        repair_ghist <= {head_entry.ghist[GHIST_W-2:0], resolve_taken};
      end
    end
  end

`ifdef BP_RESOLVE_STATS_EN
  bp_sat_ctr u_stat_resolves (
    .clk      (clk),
    .rst      (rst),
    .load     (1'b0),
    .load_val (32'd0),
    .inc      (resolve_ok),
    .count    (stat_resolves)
  );

  bp_sat_ctr u_stat_mispredicts (
    .clk      (clk),
    .rst      (rst),
    .load     (1'b0),
    .load_val (32'd0),
    .inc      (mispredict & ~flush),
    .count    (stat_mispredicts)
  );
`endif

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Scoreboard bench for bp_resolve_queue: stimulus pushes expected training/repair
// responses, a negedge monitor pops them whenever upd_v is seen.
module tb_bp_resolve_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        alloc_v;
  logic        alloc_rdy;
  logic [31:0] alloc_pc;
  logic [11:0] alloc_ghist;
  logic        alloc_pred;
  logic        resolve_v;
  logic        resolve_rdy;
  logic        resolve_taken;
  logic        upd_v;
  logic [11:0] upd_idx;
  logic        upd_taken;
  logic        repair_v;
  logic [11:0] repair_ghist;
  logic [3:0]  occupancy;
`ifdef BP_RESOLVE_STATS_EN
  logic [31:0] stat_resolves;
  logic [31:0] stat_mispredicts;
`endif

  logic        sc_load;
  logic [31:0] sc_load_val;
  logic        sc_inc;
  logic [31:0] sc_count;

  always #5 clk = ~clk;

  bp_resolve_queue dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .alloc_v       (alloc_v),
    .alloc_rdy     (alloc_rdy),
    .alloc_pc      (alloc_pc),
    .alloc_ghist   (alloc_ghist),
    .alloc_pred    (alloc_pred),
    .resolve_v     (resolve_v),
    .resolve_rdy   (resolve_rdy),
    .resolve_taken (resolve_taken),
    .upd_v         (upd_v),
    .upd_idx       (upd_idx),
    .upd_taken     (upd_taken),
    .repair_v      (repair_v),
    .repair_ghist  (repair_ghist),
    .occupancy     (occupancy)
`ifdef BP_RESOLVE_STATS_EN
    ,
    .stat_resolves    (stat_resolves),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  bp_sat_ctr u_sc (
    .clk      (clk),
    .rst      (rst),
    .load     (sc_load),
    .load_val (sc_load_val),
    .inc      (sc_inc),
    .count    (sc_count)
  );

  typedef struct {
    logic [31:0] pc;
    logic [11:0] gh;
    logic        pred;
  } ent_t;

  typedef struct {
    logic [11:0] idx;
    logic        taken;
    logic        rep;
    logic [11:0] rgh;
  } exp_t;

  ent_t mq[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (upd_v === 1'b1) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_upd", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_upd_idx", upd_idx, e.idx);
          check("sb_upd_taken", upd_taken, e.taken);
          check("sb_repair_v", repair_v, e.rep);
          if (e.rep) check("sb_repair_ghist", repair_ghist, e.rgh);
        end
      end else if (repair_v === 1'b1) begin
        check("sb_repair_without_upd", 32'd1, 32'd0);
      end
    end
  end

  // Drives one cycle of stimulus and advances the reference queue model.
  task automatic cyc(input bit av, input logic [31:0] pc, input logic [11:0] gh, input bit pr,
                     input bit rv, input bit rt, input bit fl);
    bit   ok_a, ok_r, mis;
    ent_t e, n;
    exp_t x;
    alloc_v = av; alloc_pc = pc; alloc_ghist = gh; alloc_pred = pr;
    resolve_v = rv; resolve_taken = rt; flush = fl;
    mis = 1'b0;
    if (fl) begin
      mq.delete();
    end else begin
      ok_a = av && (mq.size() < 8);
      ok_r = rv && (mq.size() > 0);
      if (ok_r) begin
        e = mq.pop_front();
        mis = (rt != e.pred);
        x.idx = ((e.pc >> 2) & 32'hFFF) ^ {20'd0, e.gh};
        x.taken = rt;
        x.rep = mis;
        x.rgh = ((e.gh << 1) | {11'd0, rt}) & 12'hFFF;
        sb.push_back(x);
        if (mis) mq.delete();
      end
      if (ok_a && !mis) begin
        n.pc = pc; n.gh = gh; n.pred = pr;
        mq.push_back(n);
      end
    end
    @(posedge clk); #1;
    alloc_v = 1'b0; resolve_v = 1'b0; flush = 1'b0;
  endtask

  task automatic alloc(input logic [31:0] pc, input logic [11:0] gh, input bit pr);
    cyc(1'b1, pc, gh, pr, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic resolve(input bit rt);
    cyc(1'b0, 32'd0, 12'd0, 1'b0, 1'b1, rt, 1'b0);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; alloc_v = 1'b0; alloc_pc = '0; alloc_ghist = '0;
    alloc_pred = 1'b0; resolve_v = 1'b0; resolve_taken = 1'b0;
    sc_load = 1'b0; sc_load_val = '0; sc_inc = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_occ", occupancy, 0);
    check("rst_upd_v", upd_v, 0);
    check("rst_repair_v", repair_v, 0);
    check("rst_upd_idx", upd_idx, 0);
    check("rst_repair_ghist", repair_ghist, 0);
    check("rst_alloc_rdy", alloc_rdy, 1);
    check("rst_resolve_rdy", resolve_rdy, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Single correct resolve.
    alloc(32'h100, 12'h0A5, 1'b1);
    check("t1_occ", occupancy, 1);
    resolve(1'b1);
    check("t1_upd_v", upd_v, 1);
    check("t1_upd_idx", upd_idx, 12'h0E5);
    check("t1_upd_taken", upd_taken, 1);
    check("t1_repair_v", repair_v, 0);
    @(posedge clk); #1;
    check("t1_upd_pulse", upd_v, 0);
    check("t1_idx_hold", upd_idx, 12'h0E5);

    // Fill, then a correct resolve with a dropped alloc.
    for (int i = 0; i < 8; i++) alloc(32'h400 + 32'(i * 4), 12'(i), 1'b1);
    check("t2_occ_full", occupancy, 8);
    check("t2_alloc_rdy", alloc_rdy, 0);
    cyc(1'b1, 32'h500, 12'h055, 1'b1, 1'b1, 1'b1, 1'b0);
    check("t2_occ_after", occupancy, 7);
    for (int i = 0; i < 7; i++) resolve(1'b1);
    check("t2_drained", occupancy, 0);
    check("t2_resolve_rdy", resolve_rdy, 0);

    // Mispredict on the oldest with younger entries and a wrong-path alloc.
    alloc(32'h200, 12'hFFF, 1'b0);
    for (int i = 0; i < 3; i++) alloc(32'h300 + 32'(i * 4), 12'h011, 1'b1);
    check("t3_occ", occupancy, 4);
    cyc(1'b1, 32'h600, 12'h123, 1'b1, 1'b1, 1'b1, 1'b0);
    check("t3_repair_v", repair_v, 1);
    check("t3_repair_ghist", repair_ghist, 12'hFFF);
    check("t3_upd_idx", upd_idx, 12'hF7F);
    check("t3_occ", occupancy, 0);
    @(posedge clk); #1;
    check("t3_repair_pulse", repair_v, 0);
    check("t3_rgh_hold", repair_ghist, 12'hFFF);

    // Flush beats same-cycle alloc and resolve.
    for (int i = 0; i < 3; i++) alloc(32'h700 + 32'(i * 4), 12'h0F0, 1'b1);
    cyc(1'b1, 32'h800, 12'h001, 1'b0, 1'b1, 1'b0, 1'b1);
    check("t4_occ", occupancy, 0);
    check("t4_upd_v", upd_v, 0);
    check("t4_repair_v", repair_v, 0);

    // Reset mid-operation clears entries and the pending strobe.
    alloc(32'h900, 12'h00C, 1'b1);
    alloc(32'h904, 12'h00D, 1'b1);
    resolve(1'b1);
    check("rm_upd_v_before", upd_v, 1);
    rst = 1'b0;
    #1;
    check("rm_upd_v", upd_v, 0);
    check("rm_occ", occupancy, 0);
    void'(sb.pop_back());
    mq.delete();
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // Five resolves, two of them mispredicted.
    for (int k = 0; k < 5; k++) begin
      alloc(32'hA00 + 32'(k * 16), 12'(k * 3), 1'b1);
      resolve((k == 1 || k == 3) ? 1'b0 : 1'b1);
    end
`ifdef BP_RESOLVE_STATS_EN
    check("t6_stat_resolves", stat_resolves, 5);
    check("t6_stat_mispredicts", stat_mispredicts, 2);
`endif

    // Streaming alloc/resolve pairs across pointer wrap.
    alloc(32'h1000, 12'h3C3, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      bit rt;
      rt = mq[0].pred;
      cyc(1'b1, 32'h1000 + 32'(i * 68), 12'(i * 37), i[0], 1'b1, rt, 1'b0);
      check("t5_occ", occupancy, 1);
    end
    resolve(mq[0].pred);
    check("t5_empty", occupancy, 0);

    // Saturating counter holds at all-ones.
    sc_load = 1'b1; sc_load_val = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    sc_load = 1'b0; sc_inc = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("sc_saturate", sc_count, 32'hFFFF_FFFF);
    sc_inc = 1'b0; sc_load = 1'b1; sc_load_val = 32'd5;
    @(posedge clk); #1;
    sc_load = 1'b0; sc_inc = 1'b1;
    @(posedge clk); #1;
    sc_inc = 1'b0;
    check("sc_increment", sc_count, 32'd6);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
